// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for the five-stage pipe, with MDU occupancy tracking.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic       id_mdu_start,
    input  logic       id_mdu_use,
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rt,
    input  logic       ex_branch_taken,
    output logic       pc_we,
    output logic       if_id_we,
    output logic       if_id_flush,
    output logic       id_ex_mux,
    output logic       mdu_busy,
    output logic       mdu_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int CW = $clog2(MDU_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(MDU_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rs_hit;
    logic          rt_hit;
    logic          load_use;
    logic          mdu_stall;
    logic          start_ok;

    assign rs_hit    = id_uses_rs && (id_rs == id_ex_rt);
    assign rt_hit    = id_uses_rt && (id_rt == id_ex_rt);
    assign load_use  = id_ex_memread && (id_ex_rt != 5'd0) && (rs_hit || rt_hit);
    assign mdu_stall = (state == BUSY) && (id_mdu_start || id_mdu_use);
    assign start_ok  = id_mdu_start && !ex_branch_taken && !load_use && !mdu_stall;

    // A taken branch wins over any stall: the stalled ID instruction is on the wrong path.
    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_mux   = 1'b0;
        if (!rst) begin
            if (ex_branch_taken) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
            end else if (load_use || mdu_stall) begin
                pc_we = 1'b0;
            end else if (id_jump) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_mux   = 1'b1;
            end else begin
                pc_we     = 1'b1;
                if_id_we  = 1'b1;
                id_ex_mux = 1'b1;
            end
        end
    end

    // Branches never abort BUSY: the mul/div is older than the branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mdu_busy <= 1'b0;
            mdu_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state    <= BUSY;
                        cnt      <= RELOAD;
                        mdu_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state    <= DONE;
                        mdu_busy <= 1'b0;
                        mdu_done <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    mdu_done <= 1'b0;
                    if (start_ok) begin
                        state    <= BUSY;
                        cnt      <= RELOAD;
                        mdu_busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    mdu_busy <= 1'b0;
                    mdu_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (if_id_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage CPU. Each cycle it combinationally decides the write enables and flush controls for the PC, IF/ID and ID/EX registers. Inputs are load-use hazards, taken branches resolved in EX, jumps decoded in ID, and a multi-cycle multiply/divide unit (MDU). A small FSM tracks MDU occupancy and issues a completion pulse. It drives the ID/EX register's mux select (0 = flush/bubble, 1 = pass).

## Interface
- MDU_CYCLES, 32: cycles the MDU is occupied per mul/div; legal range 1..63; counter width is $clog2(MDU_CYCLES+1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  ID instruction is j/jal/jr/jalr
- id_mdu_start  in  1  ID instruction is mult/multu/div/divu
- id_mdu_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination rt of instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID clear to nop
- id_ex_mux  out  1  ID/EX select: 0 inserts bubble, 1 passes ID
- mdu_busy  out  1  MDU occupied
- mdu_done  out  1  one-cycle pulse when MDU result ready

## Operation
- load_use = id_ex_memread & id_ex_rt!=0 & ((id_uses_rs & id_rs==id_ex_rt) | (id_uses_rt & id_rt==id_ex_rt)).
- mdu_stall = (state==BUSY) & (id_mdu_start | id_mdu_use).
- Priority, first match wins:
  - ex_branch_taken: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_mux=0. This overrides every stall.
  - load_use or mdu_stall: pc_we=0, if_id_we=0, if_id_flush=0, id_ex_mux=0.
  - id_jump: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_mux=1.
  - Otherwise: pc_we=1, if_id_we=1, if_id_flush=0, id_ex_mux=1.
- start_ok = id_mdu_start & ~ex_branch_taken & ~load_use & ~mdu_stall. A flushed or stalled mul/div never starts the MDU.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start_ok -> BUSY with cnt=MDU_CYCLES-1; otherwise stay in IDLE.
  - BUSY: cnt==0 -> DONE; otherwise cnt-1. A taken branch does not abort BUSY, because the mul/div is older than the branch.
  - DONE: start_ok -> BUSY with cnt reloaded; otherwise -> IDLE.
- mdu_busy = (state==BUSY). mdu_done = (state==DONE). Both are registered state decodes.
- While rst is high, the combinational outputs are forced to pc_we=0, if_id_we=0, if_id_flush=0, id_ex_mux=0.

## Timing
- Reset values: state IDLE, cnt 0, mdu_busy 0, mdu_done 0, pc_we 0, if_id_we 0, if_id_flush 0, id_ex_mux 0.
- Stall and flush outputs have zero latency (same cycle as inputs). FSM and counter update on the rising clk edge.
- start_ok sampled at edge T: mdu_busy is high for exactly MDU_CYCLES cycles starting at T+1, and mdu_done is high for the single following cycle.
- MDU_CYCLES=1: BUSY lasts one cycle, then DONE.
- Back-to-back: a start_ok in DONE gives no IDLE gap; mdu_done and the new mdu_busy interval are adjacent.
- Load-use stall lasts one cycle, after which the bubble reaches EX and id_ex_memread drops. A load-use hazard with id_ex_rt==0 never stalls.
- mdu_stall holds the ID instruction until the cycle mdu_done=1. In that cycle the instruction proceeds, or starts the MDU if it is a mul/div.
- rst asserted mid-BUSY: the FSM returns to IDLE immediately, cnt=0, and no mdu_done pulse is issued.

## Configuration
- HAZARD_PERF_EN defined: adds 32-bit outputs stall_cnt and flush_cnt, both reset to 0 and wrapping modulo 2^32.
  - stall_cnt increments on each cycle with pc_we=0 while rst is low.
  - flush_cnt increments on each cycle with if_id_flush=1.
- HAZARD_PERF_EN undefined: neither port nor either counter exists; all other behaviour is identical.

## Test plan
- Reset, then idle inputs: after rst deasserts, pc_we=1, if_id_we=1, if_id_flush=0, id_ex_mux=1, mdu_busy=0.
- Load-use: id_ex_memread=1, id_ex_rt=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_we=0, if_id_we=0, id_ex_mux=0. The same stimulus with id_ex_rt=0 -> no stall.
- Branch during load-use: ex_branch_taken=1 with a load-use condition present -> pc_we=1, if_id_flush=1, id_ex_mux=0. A concurrent id_mdu_start does not start the MDU.
- MDU_CYCLES=4: start at edge T -> mdu_busy high for T+1..T+4 and mdu_done at T+5. id_mdu_use held high stalls ID through T+4 and releases at T+5.
- Back-to-back mul/div: a second id_mdu_start during BUSY stalls, then starts in the DONE cycle. mdu_busy shows a one-cycle gap, with mdu_done high in that cycle.
- rst pulsed mid-BUSY with cnt=2 -> mdu_busy=0 immediately, no mdu_done pulse, and a subsequent start takes the full MDU_CYCLES.
